// File: rtl/xb_wb_pipe_pkg.sv
// xb_pkg: shared definitions for the write-back crossbar.
//   - Source slice indices of the compute units on the packed result bus.
//   - Default widths used by the interface and the top-level parameters.
//   - Population-count helpers. The crossbar uses them to tell a single
//     valid source from a multi-source collision.
package xb_pkg;

  localparam int XB_SRC_ALU = 0;
  localparam int XB_SRC_MUL = 1;
  localparam int XB_SRC_SHF = 2;

  localparam int XB_DATA_WIDTH     = 16;
  localparam int XB_ADDRESS_WIDTH  = 4;
  localparam int XB_SIGNAL_WIDTH   = 3;
  localparam int XB_COLL_CNT_WIDTH = 8;

  // The source vectors are zero-extended to 32 bits, so at most 31 CUs plus DM are supported.
  function automatic logic [5:0] xb_popcount(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

  function automatic logic xb_is_onehot(input logic [31:0] v);
    return xb_popcount(v) == 6'd1;
  endfunction

  function automatic logic xb_is_multi(input logic [31:0] v);
    return xb_popcount(v) > 6'd1;
  endfunction

endpackage

// File: rtl/xb_wb_pipe_if.sv
// xb_wb_pipe_if: all non-clock signals of the write-back crossbar.
//   Pipeline side (driven into the crossbar):
//     ps_xb_cuEn, ps_xb_dmEn   result-valid enables (per CU, data memory)
//     ps_rf_xA, ps_rf_yA       RF read addresses
//     ps_rf_wrtA               destination address of this cycle's result
//     cu_xb_rn, dm_xb_dmD      packed CU results and the DM load data
//     rf_xb_rx, rf_xb_ry       RF read data
//     xb_err_clr               clears the collision flag and counter
//   Crossbar side (driven by the crossbar):
//     xb_cu_rx, xb_cu_ry       forwarded operands (combinational)
//     xb_rf_En, xb_rf_wrtA, xb_rf_d   registered RF write
//     xb_err, xb_err_cnt       sticky collision flag and saturating count
//   The crossbar uses the slave modport. The surrounding pipeline uses the master modport.
interface xb_wb_pipe_if
  import xb_pkg::*;
#(
  parameter int DATA_WIDTH     = XB_DATA_WIDTH,
  parameter int ADDRESS_WIDTH  = XB_ADDRESS_WIDTH,
  parameter int SIGNAL_WIDTH   = XB_SIGNAL_WIDTH,
  parameter int COLL_CNT_WIDTH = XB_COLL_CNT_WIDTH
);

  logic [SIGNAL_WIDTH-1:0]            ps_xb_cuEn;
  logic                               ps_xb_dmEn;
  logic [ADDRESS_WIDTH-1:0]           ps_rf_xA;
  logic [ADDRESS_WIDTH-1:0]           ps_rf_yA;
  logic [ADDRESS_WIDTH-1:0]           ps_rf_wrtA;
  logic [SIGNAL_WIDTH*DATA_WIDTH-1:0] cu_xb_rn;
  logic [DATA_WIDTH-1:0]              dm_xb_dmD;
  logic [DATA_WIDTH-1:0]              rf_xb_rx;
  logic [DATA_WIDTH-1:0]              rf_xb_ry;
  logic                               xb_err_clr;

  logic [DATA_WIDTH-1:0]              xb_cu_rx;
  logic [DATA_WIDTH-1:0]              xb_cu_ry;
  logic                               xb_rf_En;
  logic [ADDRESS_WIDTH-1:0]           xb_rf_wrtA;
  logic [DATA_WIDTH-1:0]              xb_rf_d;
  logic                               xb_err;
  logic [COLL_CNT_WIDTH-1:0]          xb_err_cnt;

  modport master (
    output ps_xb_cuEn, ps_xb_dmEn, ps_rf_xA, ps_rf_yA, ps_rf_wrtA,
           cu_xb_rn, dm_xb_dmD, rf_xb_rx, rf_xb_ry, xb_err_clr,
    input  xb_cu_rx, xb_cu_ry, xb_rf_En, xb_rf_wrtA, xb_rf_d, xb_err, xb_err_cnt
  );

  modport slave (
    input  ps_xb_cuEn, ps_xb_dmEn, ps_rf_xA, ps_rf_yA, ps_rf_wrtA,
           cu_xb_rn, dm_xb_dmD, rf_xb_rx, rf_xb_ry, xb_err_clr,
    output xb_cu_rx, xb_cu_ry, xb_rf_En, xb_rf_wrtA, xb_rf_d, xb_err, xb_err_cnt
  );

endinterface

// File: rtl/xb_wb_pipe_fwd_mux.sv
// xb_fwd_mux: forwarding select for one CU read port.
//   rd_a                       read address of this port
//   vld_p0, wr_a_p0, data_p0   in-flight write (stage 0)
//   vld_p1, wr_a_p1, data_p1   pending registered write (stage 1)
//   rf_d                       register-file read data
//   fwd_d                      selected operand
// Stage 0 is checked first, so on back-to-back writes to one address the
// newest value wins.
module xb_fwd_mux #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic [ADDRESS_WIDTH-1:0] rd_a,
  input  logic                     vld_p0,
  input  logic [ADDRESS_WIDTH-1:0] wr_a_p0,
  input  logic [DATA_WIDTH-1:0]    data_p0,
  input  logic                     vld_p1,
  input  logic [ADDRESS_WIDTH-1:0] wr_a_p1,
  input  logic [DATA_WIDTH-1:0]    data_p1,
  input  logic [DATA_WIDTH-1:0]    rf_d,
  output logic [DATA_WIDTH-1:0]    fwd_d
);

  logic hit_p0;
  logic hit_p1;

  assign hit_p0 = vld_p0 && (rd_a == wr_a_p0);
  assign hit_p1 = vld_p1 && (rd_a == wr_a_p1);

  assign fwd_d = hit_p0 ? data_p0 :
                 hit_p1 ? data_p1 : rf_d;

endmodule

// File: rtl/xb_wb_pipe.sv
// xb_wb_pipe: write-back crossbar with a registered write-back stage.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears every registered output
//   bus    xb_wb_pipe_if.slave, which carries the enables, addresses, result data,
//          RF read data, the error clear, the forwarded operands, the registered RF
//          write and the collision status
// Each cycle one result source is picked from {DM, CU[n-1..0]}. The result is
// registered as the RF write and forwarded to both CU read ports from stage 0
// and from stage 1. When more than one source is enabled, nothing is written and
// the collision flag and the saturating counter are updated.
module xb_wb_pipe
  import xb_pkg::*;
#(
  parameter int DATA_WIDTH     = XB_DATA_WIDTH,
  parameter int ADDRESS_WIDTH  = XB_ADDRESS_WIDTH,
  parameter int SIGNAL_WIDTH   = XB_SIGNAL_WIDTH,
  parameter int COLL_CNT_WIDTH = XB_COLL_CNT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  xb_wb_pipe_if.slave  bus
);

  function automatic logic [COLL_CNT_WIDTH-1:0] sat_inc(input logic [COLL_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + COLL_CNT_WIDTH'(1);
  endfunction

  logic [SIGNAL_WIDTH:0]      src_p0;
  logic                       vld_p0;
  logic                       coll_p0;
  logic [DATA_WIDTH-1:0]      data_p0;

  logic                       vld_p1;
  logic [ADDRESS_WIDTH-1:0]   wr_a_p1;
  logic [DATA_WIDTH-1:0]      data_p1;
  logic                       err_q;
  logic [COLL_CNT_WIDTH-1:0]  err_cnt_q;

  logic [DATA_WIDTH-1:0]      fwd_x;
  logic [DATA_WIDTH-1:0]      fwd_y;

  // ---- stage 0: source select and collision detect ----
  assign src_p0  = {bus.ps_xb_dmEn, bus.ps_xb_cuEn};
  assign vld_p0  = xb_is_onehot(32'(src_p0));
  assign coll_p0 = xb_is_multi(32'(src_p0));

  always_comb begin
    data_p0 = '0;
    if (vld_p0) begin
      if (bus.ps_xb_dmEn) begin
        data_p0 = bus.dm_xb_dmD;
      end else begin
        for (int i = 0; i < SIGNAL_WIDTH; i++) begin
          if (bus.ps_xb_cuEn[i]) begin
            data_p0 = bus.cu_xb_rn[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  // ---- stage 1: registered RF write and collision status ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      wr_a_p1   <= '0;
      data_p1   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      vld_p1  <= vld_p0;
      wr_a_p1 <= bus.ps_rf_wrtA;
      data_p1 <= data_p0;
      if (coll_p0) begin
        // A collision in the same cycle as a clear counts as the first event after the clear.
        err_q     <= 1'b1;
        err_cnt_q <= bus.xb_err_clr ? COLL_CNT_WIDTH'(1) : sat_inc(err_cnt_q);
      end else if (bus.xb_err_clr) begin
        err_q     <= 1'b0;
        err_cnt_q <= '0;
      end
    end
  end

  assign bus.xb_rf_En   = vld_p1;
  assign bus.xb_rf_wrtA = wr_a_p1;
  assign bus.xb_rf_d    = data_p1;
  assign bus.xb_err     = err_q;
  assign bus.xb_err_cnt = err_cnt_q;

  // ---- forwarding to the CU read ports ----
  xb_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd_x (
    .rd_a    (bus.ps_rf_xA),
    .vld_p0  (vld_p0),
    .wr_a_p0 (bus.ps_rf_wrtA),
    .data_p0 (data_p0),
    .vld_p1  (vld_p1),
    .wr_a_p1 (wr_a_p1),
    .data_p1 (data_p1),
    .rf_d    (bus.rf_xb_rx),
    .fwd_d   (fwd_x)
  );

  xb_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd_y (
    .rd_a    (bus.ps_rf_yA),
    .vld_p0  (vld_p0),
    .wr_a_p0 (bus.ps_rf_wrtA),
    .data_p0 (data_p0),
    .vld_p1  (vld_p1),
    .wr_a_p1 (wr_a_p1),
    .data_p1 (data_p1),
    .rf_d    (bus.rf_xb_ry),
    .fwd_d   (fwd_y)
  );

  assign bus.xb_cu_rx = fwd_x;
  assign bus.xb_cu_ry = fwd_y;

endmodule
